// File: rtl/johnson_phase_checker.sv
// Phase decoder and integrity monitor for an N-bit Johnson (twisted-ring) counter bus.
// Decodes each enabled sample to a phase index and flags illegal codes and out-of-sequence steps.
module johnson_phase_checker #(
  parameter int N     = 2,
  parameter int CNT_W = 8,
  localparam int PW   = $clog2(2 * N)
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [N-1:0]     I,
  input  logic             CE,
  input  logic             CLR,
  output logic [PW-1:0]    PHASE,
  output logic             VALID,
  output logic             WRAP,
  output logic             ERR,
  output logic             ERR_STICKY,
  output logic [CNT_W-1:0] ERR_COUNT,
  output logic             state_dbg
);

  // Handshake: a sample on I is consumed on every rising CLK edge where CE=1
  // (no backpressure); VALID/WRAP/ERR are single-cycle pulses one edge later.

  typedef enum logic {SYNC = 1'b0, TRACK = 1'b1} state_t;

  localparam logic [PW-1:0]    LAST    = PW'(2 * N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, state_nxt;
  logic [N-1:0]      inv_code;
  logic              legal;
  logic [PW-1:0]     pop;
  logic [PW-1:0]     decoded;
  logic [PW-1:0]     phase_succ;
  logic [PW-1:0]     phase_d;
  logic              valid_d, wrap_d, err_d;
  logic              sticky_d;
  logic [CNT_W-1:0]  count_base, count_d;

  // A legal code is a run of ones from the LSB, or the complement of one.
  always_comb begin
    inv_code = ~I;
    legal    = ((I & (I + N'(1))) == '0) || ((inv_code & (inv_code + N'(1))) == '0);
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + PW'(I[i]);
    end
    // Modular subtraction keeps 2N-p correct even when 2N itself overflows PW bits.
    decoded    = I[N-1] ? (PW'(2 * N) - pop) : pop;
    phase_succ = (PHASE == LAST) ? '0 : PHASE + PW'(1);
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state <= SYNC;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: any illegal code drops the reference phase
  always_comb begin
    state_nxt = state;
    if (CE) begin
      state_nxt = legal ? TRACK : SYNC;
    end
  end

  // Output logic (registered below)
  always_comb begin
    phase_d = PHASE;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (CE) begin
      if (!legal) begin
        err_d = 1'b1;
      end else begin
        phase_d = decoded;
        valid_d = 1'b1;
        if (state == TRACK) begin
          if (decoded == phase_succ) begin
            wrap_d = (PHASE == LAST);
          end else begin
            err_d = 1'b1;
          end
        end
      end
    end
  end

  // CLR acts first so a coincident error is still recorded.
  always_comb begin
    count_base = CLR ? '0 : ERR_COUNT;
    sticky_d   = (CLR ? 1'b0 : ERR_STICKY) | err_d;
    count_d    = count_base;
    if (err_d && (count_base != CNT_MAX)) begin
      count_d = count_base + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      PHASE      <= '0;
      VALID      <= 1'b0;
      WRAP       <= 1'b0;
      ERR        <= 1'b0;
      ERR_STICKY <= 1'b0;
      ERR_COUNT  <= '0;
    end else begin
      PHASE      <= phase_d;
      VALID      <= valid_d;
      WRAP       <= wrap_d;
      ERR        <= err_d;
      ERR_STICKY <= sticky_d;
      ERR_COUNT  <= count_d;
    end
  end

  assign state_dbg = state;

endmodule
